// File: rtl/mmio_periph_ctrl_if.sv
// Core-side memory bus for mmio_periph_ctrl.
// we/a/wd from the core, combinational rd/sel back.
interface mmio_periph_ctrl_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;

  modport master (
    output we, a, wd,
    input  rd, sel
  );

  modport slave (
    input  we, a, wd,
    output rd, sel
  );
endinterface

// File: rtl/mmio_periph_ctrl.sv
// MMIO peripheral: debounced switches, LEDs, hex 7-seg, prescaled timer.
// Ports: clk, reset (async high), bus (we/a/wd/rd/sel), switches, leds, segs, irq.
module mmio_periph_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int N_SW            = 4,
  parameter int N_LED           = 4,
  parameter int NUM_DIGITS      = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRESCALE        = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  mmio_periph_ctrl_if.slave       bus,
  input  logic [N_SW-1:0]         switches,
  output logic [N_LED-1:0]        leds,
  output logic [7*NUM_DIGITS-1:0] segs,
  output logic                    irq
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [31:0] off;
  logic [2:0]  idx;
  logic        wr_en;

  // Offset compare also rejects addresses below the base (they wrap high).
  assign off     = bus.a - BASE_ADDR;
  assign bus.sel = (off < 32'd32);
  assign idx     = off[4:2];
  assign wr_en   = bus.we & bus.sel;

  logic wr_led, wr_seg, wr_tcnt, wr_tcmp;
  logic wr_ctrl, wr_stat;

  assign wr_led  = wr_en && (idx == 3'd1);
  assign wr_seg  = wr_en && (idx == 3'd2);
  assign wr_tcnt = wr_en && (idx == 3'd3);
  assign wr_tcmp = wr_en && (idx == 3'd4);
  assign wr_ctrl = wr_en && (idx == 3'd5);
  assign wr_stat = wr_en && (idx == 3'd6);

  logic [N_LED-1:0]         led_q;
  logic [DW-1:0]            seg_q;
  logic [31:0]              tcnt;
  logic [31:0]              tcmp;
  logic [1:0]               ctrl;
  logic                     match;
  logic                     sw_chg;
  logic [PW-1:0]            pre;
  logic [N_SW-1:0]          sync1;
  logic [N_SW-1:0]          sync2;
  logic [N_SW-1:0]          stable;
  logic [N_SW-1:0]          stable_d;
  logic [N_SW-1:0][CW-1:0]  db_cnt;
  logic [N_SW-1:0][CW-1:0]  cnt_d;

  always_comb begin
    stable_d = stable;
    cnt_d    = '0;
    for (int i = 0; i < N_SW; i++) begin
      if (sync2[i] != stable[i]) begin
        if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1))
          stable_d[i] = sync2[i];
        else
          cnt_d[i] = db_cnt[i] + 1'b1;
      end
    end
  end

  logic        tick;
  logic [31:0] tcnt_inc;
  logic        sw_set;
  logic        hit;

  assign tick     = ctrl[0] && (pre == PW'(PRESCALE - 1));
  assign tcnt_inc = tcnt + 32'd1;
  assign sw_set   = |(stable_d ^ stable);
  // A direct TCNT load never raises match.
  assign hit      = tick & ~wr_tcnt & (tcnt_inc == tcmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q  <= '0;
      seg_q  <= '0;
      tcnt   <= '0;
      tcmp   <= '0;
      ctrl   <= '0;
      match  <= 1'b0;
      sw_chg <= 1'b0;
      pre    <= '0;
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      db_cnt <= '0;
    end else begin
      sync1  <= switches;
      sync2  <= sync1;
      stable <= stable_d;
      db_cnt <= cnt_d;
      if (wr_led)  led_q <= bus.wd[N_LED-1:0];
      if (wr_seg)  seg_q <= bus.wd[DW-1:0];
      if (wr_tcmp) tcmp  <= bus.wd;
      if (wr_ctrl) ctrl  <= bus.wd[1:0];
      if (wr_tcnt) begin
        tcnt <= bus.wd;
        pre  <= '0;
      end else if (ctrl[0]) begin
        pre <= tick ? '0 : pre + 1'b1;
        if (tick) tcnt <= tcnt_inc;
      end
      // Hardware set wins over a same-edge W1C.
      match  <= (match & ~(wr_stat & bus.wd[0])) | hit;
      sw_chg <= (sw_chg & ~(wr_stat & bus.wd[1])) | sw_set;
    end
  end

  always_comb begin
    bus.rd = '0;
    if (bus.sel) begin
      case (idx)
        3'd0:    bus.rd = 32'(stable);
        3'd1:    bus.rd = 32'(led_q);
        3'd2:    bus.rd = 32'(seg_q);
        3'd3:    bus.rd = tcnt;
        3'd4:    bus.rd = tcmp;
        3'd5:    bus.rd = {30'd0, ctrl};
        3'd6:    bus.rd = {30'd0, sw_chg, match};
        default: bus.rd = '0;
      endcase
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    assign segs[7*k +: 7] = hex7(seg_q[4*k +: 4]);
  end

  assign leds = led_q;
  assign irq  = match & ctrl[1];

endmodule

// File: tb/tb_mmio_periph_ctrl.sv
// Directed bench for mmio_periph_ctrl with an expected-value queue.
// u0 uses defaults; u1 uses PRESCALE=3.
`timescale 1ns/1ps
module tb_mmio_periph_ctrl;

  localparam logic [31:0] B = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  switches;
  logic [3:0]  leds0, leds1;
  logic [13:0] segs0, segs1;
  logic        irq0, irq1;

  always #10 clk = ~clk;

  mmio_periph_ctrl_if bus0();
  mmio_periph_ctrl_if bus1();

  mmio_periph_ctrl u0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .switches(switches), .leds(leds0),
    .segs(segs0), .irq(irq0)
  );

  mmio_periph_ctrl #(.PRESCALE(3)) u1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .switches(switches), .leds(leds1),
    .segs(segs1), .irq(irq1)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got %h required an entry", act);
    end else begin
      e = sb.pop_front();
      assert (act === e.val) else begin
        errors++;
        $error("FAIL %s: got %h required %h", e.tag, act, e.val);
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [31:0] ad, input logic [31:0] d);
    bus0.a = ad; bus0.wd = d; bus0.we = 1'b1;
    @(posedge clk); #1;
    bus0.we = 1'b0; bus0.a = '0;
  endtask

  task automatic rd0(input logic [31:0] ad, output logic [31:0] d);
    bus0.a = ad; #1;
    d = bus0.rd;
  endtask

  task automatic wr1(input logic [31:0] ad, input logic [31:0] d);
    bus1.a = ad; bus1.wd = d; bus1.we = 1'b1;
    @(posedge clk); #1;
    bus1.we = 1'b0; bus1.a = '0;
  endtask

  task automatic rd1(input logic [31:0] ad, output logic [31:0] d);
    bus1.a = ad; #1;
    d = bus1.rd;
  endtask

  logic [31:0] r;

  initial begin
    reset = 1'b1; switches = '0;
    bus0.we = 0; bus0.a = '0; bus0.wd = '0;
    bus1.we = 0; bus1.a = '0; bus1.wd = '0;
    cycles(2);
    reset = 1'b0;

    // dirty state, then raise irq
    wr0(B + 32'h08, 32'h12);
    wr0(B + 32'h04, 32'hF);
    wr0(B + 32'h10, 32'd1);
    wr0(B + 32'h14, 32'd3);
    cycles(1);
    push("pre_reset_irq", 32'd1); check(32'(irq0));

    // asynchronous reset mid-cycle
    #5 reset = 1'b1; #1;
    push("rst_leds", 32'd0);      check(32'(leds0));
    push("rst_irq", 32'd0);       check(32'(irq0));
    push("rst_segs", 32'h1FBF);   check(32'(segs0));
    for (int i = 0; i < 8; i++) begin
      rd0(B + 32'(i * 4), r);
      push($sformatf("rst_rd%0d", i), 32'd0); check(r);
    end
    cycles(1);
    reset = 1'b0;

    // seg decode, upper bits dropped
    wr0(B + 32'h08, 32'h1234_56A5);
    push("seg_d0", 32'h6D); check(32'(segs0[6:0]));
    push("seg_d1", 32'h77); check(32'(segs0[13:7]));
    rd0(B + 32'h0A, r);
    push("seg_rd", 32'hA5); check(r);

    wr0(B + 32'h04, 32'h1005);
    push("led_out", 32'h5); check(32'(leds0));
    rd0(B + 32'h04, r);
    push("led_rd", 32'h5); check(r);

    // out-of-window accesses
    bus0.a = B + 32'h20; #1;
    push("oow_sel", 32'd0); check(32'(bus0.sel));
    push("oow_rd", 32'd0);  check(bus0.rd);
    wr0(B + 32'h20, 32'hFF);
    wr0(B - 32'h4, 32'hFF);
    wr0(B + 32'h1C, 32'hFF);
    push("oow_led", 32'h5); check(32'(leds0));
    rd0(B + 32'h1C, r);
    push("rd_1c", 32'd0); check(r);
    rd0(B + 32'h1F, r);
    push("sel_top", 32'd1); check(32'(bus0.sel));

    // debounce: 2 + 4 cycles
    switches = 4'h3;
    cycles(5);
    rd0(B, r);
    push("sw_early", 32'h0); check(r);
    cycles(1);
    rd0(B, r);
    push("sw_6cyc", 32'h3); check(r);
    rd0(B + 32'h18, r);
    push("stat_chg", 32'h2); check(r);
    wr0(B + 32'h18, 32'h2);
    rd0(B + 32'h18, r);
    push("stat_w1c", 32'h0); check(r);

    // 3-cycle glitch
    switches = 4'h8;
    cycles(3);
    switches = 4'h3;
    cycles(8);
    rd0(B, r);
    push("glitch_sw", 32'h3); check(r);
    rd0(B + 32'h18, r);
    push("glitch_chg", 32'h0); check(r);

    // timer match, PRESCALE=1
    wr0(B + 32'h10, 32'd5);
    wr0(B + 32'h14, 32'd3);
    cycles(4);
    rd0(B + 32'h0C, r);
    push("tcnt4", 32'd4); check(r);
    push("irq4", 32'd0);  check(32'(irq0));
    cycles(1);
    rd0(B + 32'h0C, r);
    push("tcnt5", 32'd5); check(r);
    push("irq5", 32'd1);  check(32'(irq0));
    rd0(B + 32'h18, r);
    push("match5", 32'h1); check(r);
    wr0(B + 32'h18, 32'h1);
    push("irq_clr", 32'd0); check(32'(irq0));
    wr0(B + 32'h14, 32'd0);

    // wrap without flag
    wr0(B + 32'h10, 32'd7);
    wr0(B + 32'h0C, 32'hFFFF_FFFE);
    wr0(B + 32'h14, 32'd1);
    cycles(1);
    rd0(B + 32'h0C, r);
    push("wrap_ff", 32'hFFFF_FFFF); check(r);
    cycles(1);
    rd0(B + 32'h0C, r);
    push("wrap_0", 32'd0); check(r);
    rd0(B + 32'h18, r);
    push("wrap_nomatch", 32'd0); check(r);

    // set wins over same-edge W1C
    wr0(B + 32'h0C, 32'd5);
    rd0(B + 32'h0C, r);
    push("load5", 32'd5); check(r);
    cycles(1);
    wr0(B + 32'h18, 32'h1);
    rd0(B + 32'h18, r);
    push("set_wins", 32'h1); check(r);
    wr0(B + 32'h18, 32'h1);
    wr0(B + 32'h14, 32'd0);
    wr0(B + 32'h0C, 32'd7);
    rd0(B + 32'h18, r);
    push("load_nomatch", 32'd0); check(r);
    rd0(B + 32'h0C, r);
    push("load7", 32'd7); check(r);

    // PRESCALE=3 on u1
    wr1(B + 32'h14, 32'd1);
    cycles(2);
    rd1(B + 32'h0C, r);
    push("ps_t0", 32'd0); check(r);
    cycles(1);
    rd1(B + 32'h0C, r);
    push("ps_t1", 32'd1); check(r);
    cycles(3);
    rd1(B + 32'h0C, r);
    push("ps_t2", 32'd2); check(r);
    wr1(B + 32'h14, 32'd0);
    cycles(5);
    rd1(B + 32'h0C, r);
    push("ps_hold", 32'd2); check(r);
    wr1(B + 32'h14, 32'd1);
    cycles(1);
    rd1(B + 32'h0C, r);
    push("ps_phase_a", 32'd2); check(r);
    cycles(1);
    rd1(B + 32'h0C, r);
    push("ps_phase_b", 32'd3); check(r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
